// File: rtl/decode_stage.sv
// decode_stage: register file with write-first bypass, control/immediate decode and the
// ID/EX register, with valid/ready handshake, load-use stall and flush.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [1:0]      out_ALUOp,
    output logic            out_RegWrite,
    output logic            out_ALUSrc,
    output logic            out_MemWrite,
    output logic            out_MemRead,
    output logic            out_MemtoReg,
    output logic [1:0]      out_Branch,
    output logic            out_is_jal,
    output logic            out_illegal
);
    logic [XLEN-1:0] r_rf [NREG];
    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [AW-1:0]   r_rs1, r_rs2, r_rd;
    logic [10:0]     r_ctrl;
    logic [AW-1:0]   w_rs1, w_rs2, w_rd;
    logic [10:0]     w_ctrl;
    logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
    logic            w_use1, w_use2, w_hazard, w_advance, w_accept, w_wr;

    assign w_rs1 = inst[15 +: AW];
    assign w_rs2 = inst[20 +: AW];
    assign w_rd  = inst[7 +: AW];

    // ctrl = {ALUOp[1:0], RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch[1:0], is_jal, illegal}
    always_comb begin
        w_ctrl = 11'b00000000001;
        w_imm  = '0;
        w_use2 = 1'b0;
        case (inst[6:0])
            7'b0110011: begin w_ctrl = 11'b10100000000; w_use2 = 1'b1; end
            7'b0010011: begin w_ctrl = 11'b11110000000; w_imm = XLEN'($signed(inst[31:20])); end
            7'b0000011: begin w_ctrl = 11'b00110110000; w_imm = XLEN'($signed(inst[31:20])); end
            7'b0100011: begin
                w_ctrl = 11'b00011000000;
                w_use2 = 1'b1;
                w_imm  = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            7'b1100011: begin
                w_ctrl = {9'b010000000, inst[14] ? 2'b10 : 2'b01, 2'b00} >> 2;
                w_ctrl = {2'b01, 5'b00000, inst[14] ? 2'b10 : 2'b01, 2'b00};
                w_use2 = 1'b1;
                w_imm  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            7'b1101111: begin
                w_ctrl = 11'b00100001110;
                w_imm  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            default: ;
        endcase
    end

    assign w_use1     = ~w_ctrl[1] & ~w_ctrl[0];
    assign w_wr       = wb_en && wb_addr != '0;
    assign w_rs1_data = w_rs1 == '0 ? '0 : (wb_en && wb_addr == w_rs1) ? wb_data : r_rf[w_rs1];
    assign w_rs2_data = w_rs2 == '0 ? '0 : (wb_en && wb_addr == w_rs2) ? wb_data : r_rf[w_rs2];
    assign w_hazard   = r_valid & r_ctrl[5] & (r_rd != '0) & in_valid &
                        ((w_use1 & (w_rs1 == r_rd)) | (w_use2 & (w_rs2 == r_rd)));
    assign w_advance  = ~r_valid | out_ready;
    assign w_accept   = w_advance & in_valid & ~w_hazard;
    assign in_ready   = rst & (flush | (w_advance & ~w_hazard));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else begin
            if (w_wr) r_rf[wb_addr] <= wb_data;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_advance) begin
                r_valid <= w_accept;
                if (w_accept) begin
                    r_pc       <= in_pc;
                    r_rs1_data <= w_rs1_data;
                    r_rs2_data <= w_rs2_data;
                    r_imm      <= w_imm;
                    r_rs1      <= w_rs1;
                    r_rs2      <= w_rs2;
                    r_rd       <= w_rd;
                    r_ctrl     <= w_ctrl;
                end
            end else begin
                // a held instruction must not keep a stale operand across a writeback
                if (w_wr && wb_addr == r_rs1) r_rs1_data <= wb_data;
                if (w_wr && wb_addr == r_rs2) r_rs2_data <= wb_data;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_rs1_data = r_rs1_data;
    assign out_rs2_data = r_rs2_data;
    assign out_imm      = r_imm;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_rd       = r_rd;
    assign {out_ALUOp, out_RegWrite, out_ALUSrc, out_MemWrite, out_MemRead, out_MemtoReg,
            out_Branch, out_is_jal, out_illegal} = r_ctrl;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scenario tasks push expected ID/EX packets to a scoreboard at issue and
// pop/compare them when the stage presents the instruction.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int AW = 5;
    localparam logic [10:0] C_R    = 11'b10100000000;
    localparam logic [10:0] C_I    = 11'b11110000000;
    localparam logic [10:0] C_LD   = 11'b00110110000;
    localparam logic [10:0] C_ST   = 11'b00011000000;
    localparam logic [10:0] C_BR01 = 11'b01000000100;
    localparam logic [10:0] C_BR10 = 11'b01000001000;
    localparam logic [10:0] C_JAL  = 11'b00100001110;
    localparam logic [10:0] C_ILL  = 11'b00000000001;
    typedef logic [4*XLEN+11+3*AW-1:0] pkt_t;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, wb_en = 1'b0, out_ready = 1'b1;
    logic [31:0] inst = '0;
    logic [XLEN-1:0] in_pc = '0, wb_data = '0;
    logic [AW-1:0] wb_addr = '0;
    logic in_ready, out_valid, out_RegWrite, out_ALUSrc, out_MemWrite, out_MemRead, out_MemtoReg;
    logic out_is_jal, out_illegal;
    logic [1:0] out_ALUOp, out_Branch;
    logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [AW-1:0] out_rs1, out_rs2, out_rd;
    int n_chk = 0, n_fail = 0;
    pkt_t sb[$];
    pkt_t obs, exp_p;
    logic [XLEN-1:0] mrf [32];

    decode_stage #(.XLEN(XLEN), .NREG(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_ALUOp(out_ALUOp),
        .out_RegWrite(out_RegWrite), .out_ALUSrc(out_ALUSrc), .out_MemWrite(out_MemWrite),
        .out_MemRead(out_MemRead), .out_MemtoReg(out_MemtoReg), .out_Branch(out_Branch),
        .out_is_jal(out_is_jal), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    assign obs = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_ALUOp, out_RegWrite, out_ALUSrc,
                  out_MemWrite, out_MemRead, out_MemtoReg, out_Branch, out_is_jal, out_illegal,
                  out_rs1, out_rs2, out_rd};

    function automatic logic [XLEN-1:0] mread(input logic [4:0] a);
        return a == 5'd0 ? '0 : mrf[a];
    endfunction

    function automatic pkt_t mk(input logic [XLEN-1:0] pc, input logic [31:0] i,
                                input logic [10:0] c, input logic [XLEN-1:0] imm);
        return {pc, mread(i[19:15]), mread(i[24:20]), imm, c, i[19:15], i[24:20], i[11:7]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        if (a != 5'd0) mrf[a] = d;
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [31:0] i, input logic [10:0] c,
                         input logic [XLEN-1:0] imm);
        in_valid = 1'b1;
        in_pc = pc;
        inst = i;
        sb.push_back(mk(pc, i, c, imm));
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        step;
        step;
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_chk++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", obs); end
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_regfile_read;
        set_wb(5'd5, 32'h1234);
        step;
        wb_en = 1'b0;
        issue(32'h100, {7'd0, 5'd0, 5'd5, 3'b000, 5'd7, 7'b0110011}, C_R, '0);
        step;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL add_x5_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL add_x5: got %h want %h", obs, exp_p); end
        end
    endtask

    task automatic test_bypass;
        set_wb(5'd6, 32'hAA);
        issue(32'h104, {12'hFFF, 5'd6, 3'b000, 5'd8, 7'b0010011}, C_I, 32'hFFFF_FFFF);
        step;
        wb_en = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL addi_bypass_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL addi_bypass: got %h want %h", obs, exp_p); end
        end
    endtask

    task automatic test_load_use;
        set_wb(5'd1, 32'h100);
        step;
        set_wb(5'd2, 32'h22);
        issue(32'h108, {12'd0, 5'd1, 3'b010, 5'd9, 7'b0000011}, C_LD, '0);
        step;
        wb_en = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL lw_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL lw: got %h want %h", obs, exp_p); end
        end
        in_valid = 1'b1;
        in_pc = 32'h10C;
        inst = {7'd0, 5'd2, 5'd9, 3'b000, 5'd10, 7'b0110011};
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: in_ready %b want 0", in_ready); end
        step;
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: out_valid %b want 0", out_valid); end
        set_wb(5'd9, 32'h55);
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL after_bubble_ready: in_ready %b want 1", in_ready); end
        sb.push_back(mk(32'h10C, inst, C_R, '0));
        step;
        wb_en = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL add_after_load_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL add_after_load: got %h want %h", obs, exp_p); end
        end
    endtask

    task automatic test_x0_and_jal;
        issue(32'h110, {12'd4, 5'd1, 3'b010, 5'd0, 7'b0000011}, C_LD, 32'd4);
        step;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL lw_x0_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL lw_x0: got %h want %h", obs, exp_p); end
        end
        issue(32'h114, {7'd0, 5'd2, 5'd0, 3'b000, 5'd11, 7'b0110011}, C_R, '0);
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall: in_ready %b want 1", in_ready); end
        step;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL use_x0_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL use_x0: got %h want %h", obs, exp_p); end
        end
        issue(32'h118, 32'h008000EF, C_JAL, 32'd8);
        step;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL jal_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL jal: got %h want %h", obs, exp_p); end
        end
    endtask

    task automatic test_hold;
        logic [31:0] held;
        held = {7'd0, 5'd3, 5'd1, 3'b000, 5'd12, 7'b0110011};
        issue(32'h11C, held, C_R, '0);
        step;
        out_ready = 1'b0;
        in_pc = 32'h120;
        inst = {12'd1, 5'd12, 3'b000, 5'd13, 7'b0010011};
        set_wb(5'd3, 32'h77);
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            step;
            wb_en = 1'b0;
            sb[0] = mk(32'h11C, held, C_R, '0);
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== sb[0]) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid %b ready %b got %h want %h", c, out_valid, in_ready, obs, sb[0]);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        exp_p = sb.pop_front();
        n_chk++;
        if (out_rs2_data !== 32'h77) begin n_fail++; $display("FAIL held_rs2_update: got %h want 00000077", out_rs2_data); end
        step;
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        issue(32'h124, {7'd0, 5'd0, 5'd2, 3'b000, 5'd14, 7'b0110011}, C_R, '0);
        step;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL pre_flush_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL pre_flush: got %h want %h", obs, exp_p); end
        end
        out_ready = 1'b0;
        flush = 1'b1;
        in_pc = 32'h128;
        inst = {12'd3, 5'd2, 3'b000, 5'd15, 7'b0010011};
        set_wb(5'd4, 32'h44);
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        step;
        flush = 1'b0;
        in_valid = 1'b0;
        wb_en = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: out_valid %b want 0", out_valid); end
        step;
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: out_valid %b want 0", out_valid); end
        issue(32'h12C, {7'd0, 5'd0, 5'd4, 3'b000, 5'd13, 7'b0110011}, C_R, '0);
        step;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL wb_during_flush_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL wb_during_flush: got %h want %h", obs, exp_p); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [5];
        logic [10:0] cs [5];
        logic [XLEN-1:0] ims [5];
        ins = '{{7'h7F, 5'd2, 5'd1, 3'b010, 5'b11000, 7'b0100011},
                {1'b1, 6'b111111, 5'd2, 5'd1, 3'b001, 4'b1110, 1'b1, 7'b1100011},
                {1'b0, 6'b000000, 5'd2, 5'd1, 3'b100, 4'b1000, 1'b0, 7'b1100011},
                32'h12345037,
                {12'h800, 5'd1, 3'b000, 5'd16, 7'b0010011}};
        cs = '{C_ST, C_BR01, C_BR10, C_ILL, C_I};
        ims = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd16, 32'd0, 32'hFFFF_F800};
        for (int k = 0; k < 5; k++) begin
            issue(32'h200 + 32'(k * 4), ins[k], cs[k], ims[k]);
            step;
            n_chk++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++; $display("FAIL b2b%0d_valid: got %b want 1", k, out_valid);
            end else begin
                exp_p = sb.pop_front();
                if (obs !== exp_p) begin n_fail++; $display("FAIL b2b%0d: got %h want %h", k, obs, exp_p); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall;
        issue(32'h300, {12'd0, 5'd1, 3'b010, 5'd17, 7'b0000011}, C_LD, '0);
        step;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL lw_stall_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL lw_stall: got %h want %h", obs, exp_p); end
        end
        out_ready = 1'b0;
        in_pc = 32'h304;
        inst = {7'd0, 5'd0, 5'd17, 3'b000, 5'd18, 7'b0110011};
        step;
        rst = 1'b0;
        step;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        n_chk++;
        if (out_valid !== 1'b0 || obs !== '0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_stall_reset: valid %b ready %b got %h want 0", out_valid, in_ready, obs);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        issue(32'h308, {7'd0, 5'd1, 5'd5, 3'b000, 5'd19, 7'b0110011}, C_R, '0);
        step;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL rf_cleared_valid: got %b want 1", out_valid);
        end else begin
            exp_p = sb.pop_front();
            if (obs !== exp_p) begin n_fail++; $display("FAIL rf_cleared: got %h want %h", obs, exp_p); end
        end
    endtask

    initial begin
        test_reset;
        test_regfile_read;
        test_bypass;
        test_load_use;
        test_x0_and_jal;
        test_hold;
        test_flush;
        test_back_to_back;
        test_reset_mid_stall;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule
